// File: rtl/audio_sample_bridge.sv
// Sample-path bridge: receive codec -> attenuate/tag -> ingress FIFO -> DSP,
// DSP result -> egress FIFO -> transmit codec (silence + sticky flag on underflow).
// Ports:
//   lmmi_clk_i, reset_n_i       clock, async active-low reset
//   en_i                        block enable (low = synchronous flush/idle)
//   shift_i                     attenuation right-shift amount
//   rx_valid_i, rx_data_i       receive codec strobe and word
//   dsp_valid_o/data_o/ch_o     ingress FIFO head towards the DSP, dsp_ready_i accepts
//   res_valid_i/data_i          DSP result, res_ready_o = egress can accept
//   tx_req_i, tx_data_o         transmit codec request and sign-extended word
//   rx_level_o, ovf_o, unf_o    ingress occupancy, sticky overflow/underflow
module audio_sample_bridge #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SHIFT_W    = 3,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  lmmi_clk_i,
  input  logic                  reset_n_i,
  input  logic                  en_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic                  rx_valid_i,
  input  logic [31:0]           rx_data_i,
  output logic                  dsp_valid_o,
  output logic [DATA_WIDTH-1:0] dsp_data_o,
  output logic [CH_W-1:0]       dsp_ch_o,
  input  logic                  dsp_ready_i,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  output logic                  res_ready_o,
  input  logic                  tx_req_i,
  output logic [31:0]           tx_data_o,
  output logic [LVL_W-1:0]      rx_level_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned DW1 = DATA_WIDTH + 1;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } ing_t;

  // Upper receive bits beyond the sample width carry no information.
  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_rx_bits;
    assign unused_rx_bits = ^rx_data_i[31:DATA_WIDTH];
  end

  logic                  run_q;
  logic [CH_W-1:0]       ch_cnt;
  logic                  stg_valid;
  ing_t                  stg;
  ing_t                  in_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]      in_wr_ptr, in_rd_ptr, in_level;
  logic [DATA_WIDTH-1:0] eg_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]      eg_wr_ptr, eg_rd_ptr, eg_level;

  logic signed [DATA_WIDTH-1:0] s_in;
  logic signed [DW1-1:0]        ext, rnd, sum, shr;
  logic [DATA_WIDTH-1:0]        att_c;

  // Round-half-up arithmetic shift with saturation, one bit of headroom.
  always_comb begin
    s_in = signed'(rx_data_i[DATA_WIDTH-1:0]);
    ext  = DW1'(s_in);
    rnd  = '0;
    if (shift_i != '0) rnd = DW1'(1) << (shift_i - SHIFT_W'(1));
    sum  = ext + rnd;
    shr  = sum >>> shift_i;
    if (shr[DW1-1] != shr[DW1-2])
      att_c = shr[DW1-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      att_c = shr[DATA_WIDTH-1:0];
  end

  logic in_empty, in_full, in_pop, in_push;
  logic eg_empty, eg_full, eg_pop, eg_push;
  ing_t in_head;

  // FIFO status; pointers carry one extra wrap bit so level = wr - rd.
  always_comb begin
    in_level = in_wr_ptr - in_rd_ptr;
    eg_level = eg_wr_ptr - eg_rd_ptr;
    in_empty = (in_level == '0);
    in_full  = (in_level == LVL_W'(FIFO_DEPTH));
    eg_empty = (eg_level == '0);
    eg_full  = (eg_level == LVL_W'(FIFO_DEPTH));
    in_pop   = en_i && !in_empty && dsp_ready_i;
    in_push  = en_i && stg_valid && (!in_full || in_pop);
    eg_push  = res_valid_i && res_ready_o;
    eg_pop   = en_i && tx_req_i && !eg_empty;
    in_head  = in_mem[in_rd_ptr[AW-1:0]];
  end

  // Head is masked while empty so the DSP side reads zero after reset/flush.
  assign dsp_valid_o = !in_empty;
  assign dsp_data_o  = in_empty ? '0 : in_head.data;
  assign dsp_ch_o    = in_empty ? '0 : in_head.ch;
  assign rx_level_o  = in_level;
  // run_q keeps res_ready_o low until the first clock after reset.
  assign res_ready_o = en_i && run_q && !eg_full;

  // Control state: stage, channel counter, pointers, transmit word, flags.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q     <= 1'b0;
      ch_cnt    <= '0;
      stg_valid <= 1'b0;
      stg       <= '0;
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      eg_wr_ptr <= '0;
      eg_rd_ptr <= '0;
      tx_data_o <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else if (!en_i) begin
      run_q     <= 1'b1;
      ch_cnt    <= '0;
      stg_valid <= 1'b0;
      stg       <= '0;
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      eg_wr_ptr <= '0;
      eg_rd_ptr <= '0;
      tx_data_o <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      stg_valid <= rx_valid_i;
      if (rx_valid_i) begin
        stg    <= '{ch: ch_cnt, data: att_c};
        ch_cnt <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + CH_W'(1);
      end
      if (in_push) in_wr_ptr <= in_wr_ptr + LVL_W'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + LVL_W'(1);
      if (stg_valid && in_full && !in_pop) ovf_o <= 1'b1;
      if (eg_push) eg_wr_ptr <= eg_wr_ptr + LVL_W'(1);
      if (tx_req_i) begin
        if (!eg_empty) begin
          eg_rd_ptr <= eg_rd_ptr + LVL_W'(1);
          tx_data_o <= 32'(signed'(eg_mem[eg_rd_ptr[AW-1:0]]));
        end else begin
          tx_data_o <= '0;
          unf_o     <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers only.
  always_ff @(posedge lmmi_clk_i) begin
    if (in_push) in_mem[in_wr_ptr[AW-1:0]] <= stg;
    if (eg_push) eg_mem[eg_wr_ptr[AW-1:0]] <= res_data_i;
  end

  logic unused_pop;
  assign unused_pop = eg_pop;

endmodule

// File: tb/tb_audio_sample_bridge.sv
module tb_audio_sample_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  shift;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        dsp_valid;
  logic [23:0] dsp_data;
  logic [0:0]  dsp_ch;
  logic        dsp_ready;
  logic        res_valid;
  logic [23:0] res_data;
  logic        res_ready;
  logic        tx_req;
  logic [31:0] tx_data;
  logic [2:0]  rx_level;
  logic        ovf;
  logic        unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  audio_sample_bridge dut (
    .lmmi_clk_i (clk),
    .reset_n_i  (rst_n),
    .en_i       (en),
    .shift_i    (shift),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .dsp_valid_o(dsp_valid),
    .dsp_data_o (dsp_data),
    .dsp_ch_o   (dsp_ch),
    .dsp_ready_i(dsp_ready),
    .res_valid_i(res_valid),
    .res_data_i (res_data),
    .res_ready_o(res_ready),
    .tx_req_i   (tx_req),
    .tx_data_o  (tx_data),
    .rx_level_o (rx_level),
    .ovf_o      (ovf),
    .unf_o      (unf)
  );

  typedef struct {
    logic [2:0]  sh;
    logic [31:0] din;
    logic [23:0] exp_d;
    logic        exp_ch;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] sh, input logic [31:0] d);
    shift    = sh;
    rx_data  = d;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    dsp_ready = 1'b1;
    step();
    dsp_ready = 1'b0;
  endtask

  task automatic push_res(input logic [23:0] d);
    res_valid = 1'b1;
    res_data  = d;
    step();
    res_valid = 1'b0;
  endtask

  task automatic req_tx();
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
  endtask

  logic [23:0] expq [$];

  initial begin
    vecs[0]  = '{3'd0, 32'h0012_3456, 24'h123456, 1'b0};
    vecs[1]  = '{3'd0, 32'h0000_0001, 24'h000001, 1'b1};
    vecs[2]  = '{3'd0, 32'h00AB_CDEF, 24'hABCDEF, 1'b0};
    vecs[3]  = '{3'd3, 32'h007F_FFFF, 24'h100000, 1'b1};
    vecs[4]  = '{3'd1, 32'h007F_FFFF, 24'h400000, 1'b0};
    vecs[5]  = '{3'd1, 32'h00FF_FFFD, 24'hFFFFFF, 1'b1};
    vecs[6]  = '{3'd2, 32'h00FF_FFFA, 24'hFFFFFF, 1'b0};
    vecs[7]  = '{3'd7, 32'h0080_0000, 24'hFF0000, 1'b1};
    vecs[8]  = '{3'd2, 32'h0000_0006, 24'h000002, 1'b0};
    vecs[9]  = '{3'd2, 32'h0000_0005, 24'h000001, 1'b1};
    vecs[10] = '{3'd0, 32'hAA00_0010, 24'h000010, 1'b0};
    vecs[11] = '{3'd4, 32'h00FF_FFF8, 24'h000000, 1'b1};

    rst_n = 1'b1; en = 1'b1; shift = '0; rx_valid = 1'b0; rx_data = '0;
    dsp_ready = 1'b0; res_valid = 1'b0; res_data = '0; tx_req = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_dsp_valid", 32'(dsp_valid), 32'd0);
    chk("rst_dsp_data", 32'(dsp_data), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_level", 32'(rx_level), 32'd0);
    chk("rst_flags", {30'd0, ovf, unf}, 32'd0);
    rst_n = 1'b1;
    step();

    // Attenuation / tagging vectors
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].sh, vecs[i].din);
      chk($sformatf("vec%0d_lat", i), 32'(dsp_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(dsp_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(dsp_data), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d_ch", i), 32'(dsp_ch), 32'(vecs[i].exp_ch));
      chk($sformatf("vec%0d_level", i), 32'(rx_level), 32'd1);
      pop();
      chk($sformatf("vec%0d_drained", i), 32'(dsp_valid), 32'd0);
    end
    chk("vec_no_ovf", 32'(ovf), 32'd0);

    // Overflow: six back-to-back strobes into a depth-4 FIFO
    dsp_ready = 1'b0;
    shift = '0;
    for (int i = 0; i < 6; i++) begin
      rx_data = 32'h10 + 32'(i);
      rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    step(); step();
    chk("ovf_level", 32'(rx_level), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_keep%0d_data", i), 32'(dsp_data), 32'h10 + 32'(i));
      chk($sformatf("ovf_keep%0d_ch", i), 32'(dsp_ch), 32'(i % 2));
      pop();
    end
    chk("ovf_empty", 32'(dsp_valid), 32'd0);
    send(3'd0, 32'h77);
    step();
    chk("ovf_7th_data", 32'(dsp_data), 32'h77);
    chk("ovf_7th_ch", 32'(dsp_ch), 32'd0);
    pop();
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Transmit path
    chk("tx_idle", tx_data, 32'd0);
    chk("tx_res_ready", 32'(res_ready), 32'd1);
    push_res(24'h800001);
    req_tx();
    chk("tx_neg", tx_data, 32'hFF80_0001);
    chk("tx_no_unf", 32'(unf), 32'd0);
    step();
    chk("tx_hold", tx_data, 32'hFF80_0001);
    req_tx();
    chk("tx_unf_data", tx_data, 32'd0);
    chk("tx_unf_flag", 32'(unf), 32'd1);
    push_res(24'h000001);
    push_res(24'h7FFFFF);
    push_res(24'h800000);
    push_res(24'h123456);
    chk("eg_full_ready", 32'(res_ready), 32'd0);
    push_res(24'h555555);
    req_tx(); chk("eg_pop0", tx_data, 32'h0000_0001);
    req_tx(); chk("eg_pop1", tx_data, 32'h007F_FFFF);
    req_tx(); chk("eg_pop2", tx_data, 32'hFF80_0000);
    req_tx(); chk("eg_pop3", tx_data, 32'h0012_3456);
    req_tx(); chk("eg_pop_empty", tx_data, 32'd0);
    push_res(24'h000AAA);
    res_valid = 1'b1; res_data = 24'h000BBB; tx_req = 1'b1;
    step();
    res_valid = 1'b0; tx_req = 1'b0;
    chk("eg_simul_pop", tx_data, 32'h0000_0AAA);
    req_tx();
    chk("eg_simul_push", tx_data, 32'h0000_0BBB);

    // Flush with three ingress entries queued
    send(3'd0, 32'h1); send(3'd0, 32'h2); send(3'd0, 32'h3);
    step(); step();
    chk("fl_pre_level", 32'(rx_level), 32'd3);
    en = 1'b0;
    step();
    chk("fl_level", 32'(rx_level), 32'd0);
    chk("fl_valid", 32'(dsp_valid), 32'd0);
    chk("fl_flags", {30'd0, ovf, unf}, 32'd0);
    chk("fl_tx", tx_data, 32'd0);
    chk("fl_res_ready", 32'(res_ready), 32'd0);
    send(3'd0, 32'h99);
    step();
    chk("fl_ignored", 32'(rx_level), 32'd0);
    en = 1'b1;
    step();
    send(3'd0, 32'h42);
    step();
    chk("fl_resume_data", 32'(dsp_data), 32'h42);
    chk("fl_resume_ch", 32'(dsp_ch), 32'd0);
    pop();

    // Backpressure: 100 random samples with random ready
    en = 1'b0; step(); en = 1'b1; step();
    fork
      begin : snd
        int w;
        logic [31:0] d;
        for (int i = 0; i < 100; i++) begin
          w = 0;
          while (rx_level >= 3'd4 && w < 200) begin
            step();
            w++;
          end
          if (w >= 200) chk("bp_send_timeout", 32'(w), 32'd0);
          d = $urandom;
          expq.push_back(d[23:0]);
          send(3'd0, {8'h00, d[23:0]});
          step();
        end
      end
      begin : rcv
        int n;
        int cyc;
        logic stalled;
        logic [23:0] pd;
        logic pc;
        logic [23:0] e;
        n = 0; cyc = 0; stalled = 1'b0; pd = '0; pc = 1'b0;
        while (n < 100 && cyc < 5000) begin
          if (stalled) begin
            chk("bp_hold_valid", 32'(dsp_valid), 32'd1);
            chk("bp_hold_data", 32'(dsp_data), 32'(pd));
            chk("bp_hold_ch", 32'(dsp_ch), 32'(pc));
          end
          dsp_ready = 1'($urandom_range(0, 1));
          if (dsp_valid && dsp_ready) begin
            if (expq.size() == 0) begin
              chk("bp_extra", 32'd1, 32'd0);
            end else begin
              e = expq.pop_front();
              chk("bp_data", 32'(dsp_data), 32'(e));
              chk("bp_ch", 32'(dsp_ch), 32'(n % 2));
            end
            n++;
          end
          stalled = dsp_valid && !dsp_ready;
          pd = dsp_data;
          pc = dsp_ch[0];
          step();
          cyc++;
        end
        dsp_ready = 1'b0;
        chk("bp_count", 32'(n), 32'd100);
      end
    join
    chk("bp_no_ovf", 32'(ovf), 32'd0);

    // Asynchronous reset in the middle of a burst
    push_res(24'h000123);
    req_tx();
    push_res(24'h000456);
    send(3'd0, 32'h5); send(3'd0, 32'h6);
    rx_valid = 1'b1; rx_data = 32'h7;
    #3 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("ar_valid", 32'(dsp_valid), 32'd0);
    chk("ar_data", 32'(dsp_data), 32'd0);
    chk("ar_ch", 32'(dsp_ch), 32'd0);
    chk("ar_res_ready", 32'(res_ready), 32'd0);
    chk("ar_tx", tx_data, 32'd0);
    chk("ar_level", 32'(rx_level), 32'd0);
    chk("ar_flags", {30'd0, ovf, unf}, 32'd0);
    #1 rst_n = 1'b1;
    step(); step(); step();
    chk("ar_no_partial", 32'(rx_level), 32'd0);
    req_tx();
    chk("ar_eg_empty", 32'(unf), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
